// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : RV32 ALU issue stage. Decodes funct3/funct7b5 into the ALU ctrl
//             code, registers operands, then hands the result to writeback.
//  Optional : ALU_ISSUE_CHECK_EN adds a shadow model driving sticky check_err.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue #(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_is_imm,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    output logic [2:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_rd,
    input  logic            alu_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic            check_err
);

    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0]   alu_rs1_q, alu_rs1_d;
    logic [XLEN-1:0]   alu_rs2_q, alu_rs2_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic              out_zero_q, out_zero_d;
    logic              out_illegal_q, out_illegal_d;

    logic              w_dec_legal;
    logic [2:0]        w_dec_ctrl;
    logic [XLEN-1:0]   w_opb;
    logic              w_capture;

    // funct7b5 only selects SUB for register-register forms; ADDI never subtracts.
    always_comb begin
        w_dec_legal = 1'b1;
        w_dec_ctrl  = 3'b000;
        case (in_funct3)
            3'b000:  w_dec_ctrl = (!in_is_imm && in_funct7b5) ? 3'b001 : 3'b000;
            3'b111:  w_dec_ctrl = 3'b010;
            3'b110:  w_dec_ctrl = 3'b011;
            3'b010:  w_dec_ctrl = 3'b101;
            default: w_dec_legal = 1'b0;
        endcase
    end

    assign w_opb     = in_is_imm ? in_imm : in_rs2_val;
    assign w_capture = (state_q == S_EXEC) && (cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_rs1_d     = alu_rs1_q;
        alu_rs2_d     = alu_rs2_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_illegal_d = out_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_dec_legal) begin
                        alu_ctrl_d = w_dec_ctrl;
                        alu_rs1_d  = in_rs1_val;
                        alu_rs2_d  = w_opb;
                        cnt_d      = CNT_W'(ALU_LAT);
                        state_d    = S_EXEC;
                    end else begin
                        out_result_d  = '0;
                        out_zero_d    = 1'b0;
                        out_illegal_d = 1'b1;
                        out_valid_d   = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    out_result_d  = alu_rd;
                    out_zero_d    = alu_z;
                    out_illegal_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            alu_ctrl_q    <= 3'b000;
            alu_rs1_q     <= '0;
            alu_rs2_q     <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_rs1_q     <= alu_rs1_d;
            alu_rs2_q     <= alu_rs2_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
        end
    end

`ifdef ALU_ISSUE_CHECK_EN
    logic [XLEN-1:0] w_exp_rd;
    logic            w_mismatch;
    logic            check_err_q, check_err_d;

    always_comb begin
        w_exp_rd = '0;
        case (alu_ctrl_q)
            3'b000:  w_exp_rd = alu_rs1_q + alu_rs2_q;
            3'b001:  w_exp_rd = alu_rs1_q - alu_rs2_q;
            3'b010:  w_exp_rd = alu_rs1_q & alu_rs2_q;
            3'b011:  w_exp_rd = alu_rs1_q | alu_rs2_q;
            3'b101:  w_exp_rd = {{(XLEN-1){1'b0}}, ($signed(alu_rs1_q) < $signed(alu_rs2_q))};
            default: w_exp_rd = '0;
        endcase
    end

    assign w_mismatch  = (alu_rd != w_exp_rd) || (alu_z != (w_exp_rd == '0));
    assign check_err_d = check_err_q | (w_capture & w_mismatch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            check_err_q <= 1'b0;
        end else begin
            check_err_q <= check_err_d;
        end
    end

    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

    assign in_ready    = (state_q == S_IDLE);
    assign alu_ctrl    = alu_ctrl_q;
    assign alu_rs1     = alu_rs1_q;
    assign alu_rs2     = alu_rs2_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;

endmodule
`default_nettype wire
